issue_hazard_scoreboard: RTL

- In-order, single-issue interlock between the micro-op decoder and the execute/memory stages.
- Consumes the per-micro-op register usage flags (d/s/t GPR reads, d GPR write, EFLAGS read/write) plus register indices.
- Keeps a countdown per GPR and one for EFLAGS, and stalls issue while any operand or destination is still in flight.
- Also counts stall cycles for performance debug.

---
 rtl/issue_hazard_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/issue_hazard_scoreboard.sv
// Issue interlock: per-GPR and EFLAGS busy countdowns gate in-order issue.
// Also keeps a saturating stall-cycle counter for performance debug.
module issue_hazard_scoreboard #(
    parameter int REG_N    = 16,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 2,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] d_idx,
    input  logic [IDX_W-1:0] s_idx,
    input  logic [IDX_W-1:0] t_idx,
    input  logic             d_from_gpr,
    input  logic             d_to_gpr,
    input  logic             s_from_gpr,
    input  logic             t_from_gpr,
    input  logic             from_eflags,
    input  logic             to_eflags,
    input  logic             is_load,
    input  logic             flush,
    output logic             issue,
    output logic [REG_N-1:0] gpr_busy,
    output logic             eflags_busy,
    output logic [15:0]      stall_cnt
);

    localparam logic [CNT_W-1:0] ALU_C  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [REG_N];
    logic [CNT_W-1:0] cnt_d [REG_N];
    logic [CNT_W-1:0] ef_cnt_q;
    logic [CNT_W-1:0] ef_cnt_d;
    logic             issue_q;
    logic             issue_d;
    logic [15:0]      stall_q;
    logic [15:0]      stall_d;

    logic [REG_N-1:0] busy;
    logic             ef_busy;
    logic             hazard;
    logic             accept;
    logic [CNT_W-1:0] wr_lat;

    always_comb begin
        for (int i = 0; i < REG_N; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    assign ef_busy = (ef_cnt_q != '0);

    // Reads and WAW both look at the pre-issue count, so self-use never stalls.
    assign hazard = (s_from_gpr  & busy[s_idx])
                  | (t_from_gpr  & busy[t_idx])
                  | (d_from_gpr  & busy[d_idx])
                  | (d_to_gpr    & busy[d_idx])
                  | (from_eflags & ef_busy)
                  | (to_eflags   & ef_busy);

    assign in_ready = ~hazard & ~flush & ~rst;
    assign accept   = in_valid & in_ready;
    assign wr_lat   = is_load ? LOAD_C : ALU_C;

    always_comb begin
        for (int i = 0; i < REG_N; i++) begin
            cnt_d[i] = busy[i] ? cnt_q[i] - ONE_C : cnt_q[i];
            if (accept && d_to_gpr && (d_idx == IDX_W'(i))) begin
                cnt_d[i] = wr_lat;
            end
        end
    end

    always_comb begin
        ef_cnt_d = ef_busy ? ef_cnt_q - ONE_C : ef_cnt_q;
        if (accept && to_eflags) begin
            ef_cnt_d = wr_lat;
        end
    end

    always_comb begin
        issue_d = accept;
        stall_d = stall_q;
        if (in_valid && !in_ready && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                cnt_q[i] <= '0;
            end
            ef_cnt_q <= '0;
            issue_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ef_cnt_q <= ef_cnt_d;
            issue_q  <= issue_d;
            stall_q  <= stall_d;
        end
    end

    assign issue       = issue_q;
    assign gpr_busy    = busy;
    assign eflags_busy = ef_busy;
    assign stall_cnt   = stall_q;

endmodule
